fir_out_requant: RTL and testbench



---
 rtl/fir_out_requant.sv | 133 +++++++++++++
 tb/tb_fir_out_requant.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_requant.sv
// Decimating requantiser behind fir_filter: keeps every DECIM-th valid sample,
// rounds/saturates it to WIDTH_O bits and queues it in a small valid/ready FIFO.
module fir_out_requant #(
  parameter int WIDTH_Y = 12,
  parameter int WIDTH_O = 8,
  parameter int SHIFT   = 4,
  parameter int DECIM   = 2,
  parameter int DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic signed [WIDTH_Y-1:0]          y,
  input  logic                               y_valid,
  output logic signed [WIDTH_O-1:0]          m_data,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [$clog2(DEPTH+1)-1:0]         count,
  output logic                               sat,
  output logic                               overflow
);

  localparam int PW    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int RW    = WIDTH_Y + 1;
  localparam int O_MAX = 2 ** (WIDTH_O - 1) - 1;
  localparam int O_MIN = -(2 ** (WIDTH_O - 1));
  localparam logic signed [RW-1:0] RND = RW'(2 ** (SHIFT - 1));

  logic [PW-1:0]              phase_q, phase_d;
  logic [WIDTH_O-1:0]         q_q, q_d;
  logic                       q_v_q, q_v_d;
  logic                       q_sat_q, q_sat_d;
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       sat_q, sat_d;
  logic                       overflow_q, overflow_d;
  logic [WIDTH_O-1:0]         mem_q [DEPTH];

  logic signed [RW-1:0]       y_ext;
  logic signed [RW-1:0]       sum;
  logic signed [RW-1:0]       r;
  logic                       keep;
  logic                       full;
  logic                       pop;
  logic                       wr_en;
  logic                       drop;

  // Extra headroom bit so the rounding offset can never wrap the sum.
  assign y_ext = RW'(y);
  assign sum   = y_ext + RND;
  assign r     = sum >>> SHIFT;
  assign keep  = y_valid && (phase_q == '0);

  assign full  = (count_q == CW'(DEPTH));
  assign pop   = m_valid && m_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en = q_v_q && (!full || pop);
  assign drop  = q_v_q && full && !pop;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    phase_d = phase_q;
    if (y_valid) begin
      phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
    end

    q_v_d   = keep;
    q_sat_d = 1'b0;
    q_d     = r[WIDTH_O-1:0];
    if (int'(r) > O_MAX) begin
      q_d     = WIDTH_O'(O_MAX);
      q_sat_d = 1'b1;
    end else if (int'(r) < O_MIN) begin
      q_d     = WIDTH_O'(O_MIN);
      q_sat_d = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Dropped saturated samples still report saturation.
    sat_d      = q_v_q && q_sat_q;
    overflow_d = overflow_q || drop;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_q    <= '0;
      q_q        <= '0;
      q_v_q      <= 1'b0;
      q_sat_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sat_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      q_q        <= q_d;
      q_v_q      <= q_v_d;
      q_sat_q    <= q_sat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sat_q      <= sat_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; entries are only read once count says they hold data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= q_q;
    end
  end

  assign m_valid  = (count_q != '0);
  assign m_data   = m_valid ? $signed(mem_q[rd_ptr_q]) : '0;
  assign count    = count_q;
  assign sat      = sat_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fir_out_requant.sv
// Bench for fir_out_requant: an arithmetic reference model feeds a scoreboard queue,
// and a monitor compares every accepted output plus the status flags each cycle.
module tb_fir_out_requant;

  localparam int WY  = 12;
  localparam int WO  = 8;
  localparam int SH  = 4;
  localparam int DEC = 2;
  localparam int DEP = 4;
  localparam int CW  = $clog2(DEP + 1);

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic signed [WY-1:0] y = '0;
  logic                 y_valid = 1'b0;
  logic                 m_ready = 1'b0;
  logic signed [WO-1:0] m_data;
  logic                 m_valid;
  logic [CW-1:0]        count;
  logic                 sat;
  logic                 overflow;

  fir_out_requant #(
    .WIDTH_Y (WY),
    .WIDTH_O (WO),
    .SHIFT   (SH),
    .DECIM   (DEC),
    .DEPTH   (DEP)
  ) u_dut (
    .clk      (clk),
    .rstn     (rstn),
    .y        (y),
    .y_valid  (y_valid),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .count    (count),
    .sat      (sat),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on the sample value.
  function automatic int model_round(input int v);
    return (v + (1 << (SH - 1))) >>> SH;
  endfunction

  function automatic int model_requant(input int v);
    int r;
    r = model_round(v);
    if (r > (1 << (WO - 1)) - 1) return (1 << (WO - 1)) - 1;
    if (r < -(1 << (WO - 1)))    return -(1 << (WO - 1));
    return r;
  endfunction

  function automatic bit model_is_sat(input int v);
    int r;
    r = model_round(v);
    return (r > (1 << (WO - 1)) - 1) || (r < -(1 << (WO - 1)));
  endfunction

  int m_phase    = 0;
  int m_occ      = 0;
  bit m_pend     = 1'b0;
  bit m_pend_sat = 1'b0;
  int m_pend_val = 0;
  bit exp_ovf    = 1'b0;
  bit exp_sat    = 1'b0;
  int exp_q[$];

  // Cycle model: a kept sample waits one cycle, then enters the queue unless it is full
  // with nobody taking from it.
  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_phase = 0; m_occ = 0; m_pend = 0; m_pend_sat = 0; m_pend_val = 0;
        exp_ovf = 0; exp_sat = 0;
        exp_q.delete();
      end else begin
        bit do_pop;
        do_pop  = (m_occ > 0) && m_ready;
        exp_sat = m_pend && m_pend_sat;
        if (m_pend) begin
          if (m_occ < DEP || do_pop) begin
            exp_q.push_back(m_pend_val);
            m_occ++;
          end else begin
            exp_ovf = 1'b1;
          end
        end
        if (do_pop) m_occ--;
        m_pend = y_valid && (m_phase == 0);
        if (m_pend) begin
          m_pend_val = model_requant(int'(y));
          m_pend_sat = model_is_sat(int'(y));
        end
        if (y_valid) m_phase = (m_phase + 1) % DEC;
      end
    end
  end

  // Monitor: status every cycle, data on every handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        check("count", count, m_occ);
        check("m_valid", m_valid, (m_occ > 0));
        check("overflow", overflow, exp_ovf);
        check("sat", sat, exp_sat);
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL m_data: got %0d, expected nothing queued (t=%0t)", m_data, $time);
          end else begin
            check("m_data", m_data, exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int val);
    y_valid = v;
    y       = WY'(val);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0);
  endtask

  // Aligns the phase with a throwaway sample so that val is the one kept.
  task automatic send_kept(input int val);
    for (int i = 0; i < DEC && m_phase != 0; i++) drive(1'b1, int'($urandom_range(0, 255)));
    drive(1'b1, val);
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    y_valid = 1'b0;
    m_ready = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    do_reset();
    check("reset_m_valid", m_valid, 0);
    check("reset_count", count, 0);
    check("reset_m_data", m_data, 0);

    // Rounding and two-cycle latency.
    send_kept(40);
    check("lat_edge_k", m_valid, 0);
    idle(1);
    check("lat_edge_k1_valid", m_valid, 1);
    check("round_40", m_data, 3);
    m_ready = 1'b1;
    send_kept(-24);
    send_kept(8);
    send_kept(-9);
    idle(6);

    // Saturation pulse aligned with the write.
    m_ready = 1'b0;
    send_kept(2047);
    idle(1);
    check("sat_pulse_hi", sat, 1);
    check("sat_value_hi", m_data, 127);
    idle(1);
    check("sat_one_cycle", sat, 0);
    send_kept(-2048);
    idle(1);
    check("sat_none_lo", sat, 0);
    check("sat_count", count, 2);
    m_ready = 1'b1;
    idle(6);

    // Decimation with the phase held across gaps.
    m_ready = 1'b0;
    if (m_phase != 0) drive(1'b1, 0);
    drive(1'b1, 16); drive(1'b1, 32); drive(1'b1, 48); drive(1'b1, 64);
    idle(2);
    check("decim_count", count, 2);
    check("decim_head", m_data, 1);
    idle(1);
    drive(1'b1, 80); drive(1'b1, 96);
    idle(2);
    check("decim_gap_count", count, 3);
    m_ready = 1'b1;
    idle(6);

    // Overflow with the sink stalled.
    m_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send_kept(16 * i);
    idle(2);
    check("ovf_count", count, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_head", m_data, 1);
    m_ready = 1'b1;
    idle(6);
    check("ovf_drained", m_valid, 0);
    check("ovf_sticky", overflow, 1);

    // Full FIFO with a simultaneous pop.
    do_reset();
    for (int i = 1; i <= 4; i++) send_kept(16 * i);
    idle(2);
    check("full_count", count, 4);
    send_kept(80);
    m_ready = 1'b1;
    idle(1);
    check("full_pop_count", count, 4);
    check("full_pop_no_ovf", overflow, 0);
    idle(8);

    // Asynchronous reset between edges.
    do_reset();
    send_kept(16); send_kept(32); send_kept(48);
    idle(2);
    check("pre_rst_count", count, 3);
    #2;
    rstn = 1'b0;
    #1;
    check("async_m_valid", m_valid, 0);
    check("async_count", count, 0);
    check("async_overflow", overflow, 0);
    check("async_sat", sat, 0);
    check("async_m_data", m_data, 0);
    tick();
    rstn = 1'b1;
    drive(1'b1, 16);
    idle(1);
    check("post_rst_valid", m_valid, 1);
    check("post_rst_data", m_data, 1);
    m_ready = 1'b1;
    idle(4);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int val;
      if ($urandom_range(0, 7) == 0) val = int'($urandom_range(2030, 2047));
      else if ($urandom_range(0, 7) == 0) val = -2048 + int'($urandom_range(0, 15));
      else val = int'($urandom_range(0, 4095)) - 2048;
      m_ready = ($urandom_range(0, 99) < 60);
      drive($urandom_range(0, 3) != 0, val);
    end
    m_ready = 1'b1;
    idle(12);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
